axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, giving the max consecutive data grants while inst is pending.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have i_rd_req, input, 1: inst-cache read request, held with stable addr/len until accepted.
REQ-005 SHALL have i_rd_addr, input, 32: inst read byte address.
REQ-006 SHALL have i_rd_len, input, 8: inst burst beats minus one.
REQ-007 SHALL have i_rd_addr_ok, output, 1: one-cycle pulse, inst request accepted.
REQ-008 SHALL have i_rd_valid / i_rd_last, output, 1 each: inst data beat valid / final beat.
REQ-009 SHALL have i_rd_data, output, 32: inst data beat.
REQ-010 SHALL have d_rd_req, d_rd_addr(32), d_rd_len(8), d_rd_addr_ok, d_rd_valid, d_rd_last and d_rd_data(32), mirroring REQ-004..009 for the data cache.
REQ-011 SHALL have arid(4), araddr(32), arlen(8), arsize(3), arburst(2) and arvalid(1) as outputs, plus arready(1) as input: AXI AR channel.
REQ-012 SHALL have rid(4), rdata(32), rlast(1) and rvalid(1) as inputs, plus rready(1) as output: AXI R channel.

Function
REQ-013 SHALL implement states IDLE, AR and R, with at most one outstanding read.
REQ-014 SHALL arbitrate in IDLE as follows:
- Only one requester asserted: that requester wins.
- Both asserted: data wins, unless starve_cnt == STARVE_LIMIT, in which case inst wins.
REQ-015 SHALL, in IDLE with a winner, assert the winner's *_rd_addr_ok combinationally in that cycle, latch addr/len/id, and go to AR next cycle.
REQ-016 SHALL use id 4'd0 for inst and 4'd1 for data.
REQ-017 SHALL, in AR, drive the AR channel as follows:
- arvalid=1, with araddr/arlen/arid taken from the latched values.
- arsize=3'b010 and arburst=2'b01 at all times.
- Move to R on the cycle arvalid&&arready; AR outputs stay stable until then.
REQ-018 SHALL, in R, hold rready=1 and handle beats as follows:
- A beat with rvalid && rid==latched id is forwarded to the owner's *_rd_valid/data/last in the same cycle (combinational).
- On a matching rvalid&&rlast, return to IDLE next cycle.
REQ-019 SHALL accept and discard R beats whose rid mismatches the latched id, without forwarding them and without changing state.
REQ-020 SHALL keep rready=0 in IDLE and AR.
REQ-021 SHALL hold the non-owner's *_rd_valid, *_rd_last and *_rd_addr_ok at 0 at all times.
REQ-022 SHALL keep starve_cnt (3 bits) as follows:
- +1 when data is granted while i_rd_req=1.
- Cleared to 0 when inst is granted, or when data is granted with i_rd_req=0.
- Saturates at STARVE_LIMIT.
REQ-023 SHALL not accept a new request in the IDLE-return cycle; arbitration resumes the cycle after.
REQ-024 SHALL treat a requester dropping *_rd_req before addr_ok as no request, with no grant issued.

Reset
REQ-025 SHALL, on reset=1 at any time, immediately force:
- State to IDLE and starve_cnt to 0.
- arvalid, rready and all *_addr_ok/*_valid/*_last to 0.
- araddr, arlen, arid and all *_rd_data to 0.
REQ-026 SHALL, on reset mid-burst, discard remaining beats of the interrupted burst; recovery of the slave is the system's responsibility.

Verification
REQ-027 SHALL pass: i_rd_req only, addr 0x1C000000, len 3, arready immediate, 4 beats rid 0 -> i_rd_addr_ok pulse in IDLE; AR araddr 0x1C000000/arlen 3/arid 0; 4 i_rd_valid pulses, i_rd_last on beat 4; IDLE after.
REQ-028 SHALL pass: i and d requesting simultaneously, d addr 0x00001000 -> d granted first, arid 1; inst granted in the arbitration cycle following d's rlast+1.
REQ-029 SHALL pass: d_rd_req held continuously with i pending, STARVE_LIMIT=4 -> 4 data grants, then the 5th grant goes to inst with arid 0, and starve_cnt returns to 0.
REQ-030 SHALL pass: arready held 0 for 5 cycles in AR -> arvalid stays 1 with araddr/arlen/arid unchanged; transfer to R on the 6th cycle.
REQ-031 SHALL pass: in R with latched id 1, a beat with rid 0 then a beat with rid 1 and rlast -> first beat dropped with no d/i valid; second forwarded with d_rd_last=1.
REQ-032 SHALL pass: reset asserted during beat 2 of a 4-beat burst -> outputs zero in the same cycle without waiting for clk; after release, a new d request is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// Bundle of the inst/data cache read ports and the AXI AR/R channels.
// The master modport is the arbiter's view; slave is the caches plus the AXI slave.
interface axi_rd_arbiter_if;
    logic        i_rd_req;
    logic [31:0] i_rd_addr;
    logic [7:0]  i_rd_len;
    logic        i_rd_addr_ok;
    logic        i_rd_valid;
    logic        i_rd_last;
    logic [31:0] i_rd_data;

    logic        d_rd_req;
    logic [31:0] d_rd_addr;
    logic [7:0]  d_rd_len;
    logic        d_rd_addr_ok;
    logic        d_rd_valid;
    logic        d_rd_last;
    logic [31:0] d_rd_data;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  i_rd_req, i_rd_addr, i_rd_len,
        output i_rd_addr_ok, i_rd_valid, i_rd_last, i_rd_data,
        input  d_rd_req, d_rd_addr, d_rd_len,
        output d_rd_addr_ok, d_rd_valid, d_rd_last, d_rd_data,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rlast, rvalid,
        output rready
    );

    modport slave (
        output i_rd_req, i_rd_addr, i_rd_len,
        input  i_rd_addr_ok, i_rd_valid, i_rd_last, i_rd_data,
        output d_rd_req, d_rd_addr, d_rd_len,
        input  d_rd_addr_ok, d_rd_valid, d_rd_last, d_rd_data,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter (inst/data cache), one outstanding burst at a time.
// state  | meaning
// S_IDLE | arbitrate; first cycle after a burst is a hold-off cycle with no grant
// S_AR   | present latched request on AR until arready
// S_R    | collect beats for the latched id, forward to the owner
module axi_rd_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    axi_rd_arbiter_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t      state, state_nx;
    logic        hold_off;
    logic [2:0]  starve_cnt;
    logic [31:0] lat_addr;
    logic [7:0]  lat_len;
    logic [3:0]  lat_id;
    logic        grant_i, grant_d, beat_ok, data_owner;

    assign data_owner  = (lat_id == 4'd1);
    assign bus.araddr  = lat_addr;
    assign bus.arlen   = lat_len;
    assign bus.arid    = lat_id;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (grant_i || grant_d) state_nx = S_AR;
            S_AR:   if (bus.arready) state_nx = S_R;
            S_R:    if (beat_ok && bus.rlast) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Every output is gated by reset so it drops without waiting for a clock edge.
    always_comb begin
        grant_i          = 1'b0;
        grant_d          = 1'b0;
        beat_ok          = 1'b0;
        bus.arvalid      = 1'b0;
        bus.rready       = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE: if (!hold_off) begin
                    grant_i = bus.i_rd_req && (!bus.d_rd_req || starve_cnt == LIMIT);
                    grant_d = bus.d_rd_req && !grant_i;
                end
                S_AR: bus.arvalid = 1'b1;
                S_R: begin
                    bus.rready = 1'b1;
                    beat_ok    = bus.rvalid && (bus.rid == lat_id);
                end
                default: ;
            endcase
        end
        bus.i_rd_addr_ok = grant_i;
        bus.d_rd_addr_ok = grant_d;
        bus.i_rd_valid   = beat_ok && !data_owner;
        bus.d_rd_valid   = beat_ok && data_owner;
        bus.i_rd_last    = bus.i_rd_valid && bus.rlast;
        bus.d_rd_last    = bus.d_rd_valid && bus.rlast;
        bus.i_rd_data    = bus.i_rd_valid ? bus.rdata : 32'd0;
        bus.d_rd_data    = bus.d_rd_valid ? bus.rdata : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_off   <= 1'b0;
            starve_cnt <= 3'd0;
            lat_addr   <= 32'd0;
            lat_len    <= 8'd0;
            lat_id     <= 4'd0;
        end else begin
            hold_off <= (state == S_R) && (state_nx == S_IDLE);
            if (grant_i) begin
                lat_addr   <= bus.i_rd_addr;
                lat_len    <= bus.i_rd_len;
                lat_id     <= 4'd0;
                starve_cnt <= 3'd0;
            end else if (grant_d) begin
                lat_addr <= bus.d_rd_addr;
                lat_len  <= bus.d_rd_len;
                lat_id   <= 4'd1;
                if (!bus.i_rd_req)            starve_cnt <= 3'd0;
                else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios followed by randomized bursts,
// checked against a transaction-level model of the grant rules.
module tb_axi_rd_arbiter;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_rd_arbiter_if bus();

    axi_rd_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    bit          i_pend, d_pend;
    logic [31:0] i_addr, d_addr;
    logic [7:0]  i_len,  d_len;
    int          data_streak;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        bus.i_rd_req  = i_pend;
        bus.i_rd_addr = i_addr;
        bus.i_rd_len  = i_len;
        bus.d_rd_req  = d_pend;
        bus.d_rd_addr = d_addr;
        bus.d_rd_len  = d_len;
    endtask

    // Starts in an arbitration cycle, ends after the post-burst hold-off cycle.
    task automatic run_txn(input int ar_delay, input bit inject_bad);
        bit          win_d;
        logic [31:0] a;
        logic [7:0]  l;
        logic [3:0]  id;
        logic [31:0] dat;
        drive_reqs();
        #1;
        if (i_pend && d_pend) win_d = (data_streak < STARVE_LIMIT);
        else                  win_d = d_pend;
        chk("i_addr_ok", bus.i_rd_addr_ok, !win_d);
        chk("d_addr_ok", bus.d_rd_addr_ok, win_d);
        if (win_d) begin
            data_streak = i_pend ? ((data_streak < STARVE_LIMIT) ? data_streak + 1 : STARVE_LIMIT) : 0;
            a = d_addr; l = d_len; id = 4'd1; d_pend = 1'b0;
        end else begin
            data_streak = 0;
            a = i_addr; l = i_len; id = 4'd0; i_pend = 1'b0;
        end
        tick();
        drive_reqs();
        for (int k = 0; k <= ar_delay; k++) begin
            bus.arready = (k == ar_delay);
            #1;
            chk("arvalid", bus.arvalid, 1'b1);
            chk("araddr", bus.araddr, a);
            chk("arlen", bus.arlen, l);
            chk("arid", bus.arid, id);
            chk("arsize_burst", {bus.arsize, bus.arburst}, 5'b010_01);
            chk("ar_rready", bus.rready, 1'b0);
            chk("ar_addr_ok", {bus.i_rd_addr_ok, bus.d_rd_addr_ok}, 2'b00);
            tick();
        end
        bus.arready = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
            if ($urandom_range(3) == 0) begin
                bus.rvalid = 1'b0;
                #1;
                chk("gap_valid", {bus.i_rd_valid, bus.d_rd_valid}, 2'b00);
                tick();
            end
            if (inject_bad) begin
                bus.rvalid = 1'b1;
                bus.rid    = id ^ 4'd1;
                bus.rdata  = $urandom;
                bus.rlast  = 1'b1;
                #1;
                chk("bad_rready", bus.rready, 1'b1);
                chk("bad_valid", {bus.i_rd_valid, bus.d_rd_valid, bus.i_rd_last, bus.d_rd_last}, 4'b0000);
                tick();
            end
            dat = $urandom;
            bus.rvalid = 1'b1;
            bus.rid    = id;
            bus.rdata  = dat;
            bus.rlast  = (b == int'(l));
            #1;
            chk("r_rready", bus.rready, 1'b1);
            chk("r_valid", {bus.i_rd_valid, bus.d_rd_valid}, win_d ? 2'b01 : 2'b10);
            chk("r_data", win_d ? bus.d_rd_data : bus.i_rd_data, dat);
            chk("r_last", win_d ? bus.d_rd_last : bus.i_rd_last, b == int'(l));
            chk("r_other_last", win_d ? bus.i_rd_last : bus.d_rd_last, 1'b0);
            tick();
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        drive_reqs();
        #1;
        chk("ret_addr_ok", {bus.i_rd_addr_ok, bus.d_rd_addr_ok}, 2'b00);
        chk("ret_rready", bus.rready, 1'b0);
        chk("ret_arvalid", bus.arvalid, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        i_pend = 1'b1; d_pend = 1'b1;
        i_addr = 32'h0; d_addr = 32'h0; i_len = 8'd0; d_len = 8'd0;
        data_streak = 0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        bus.rid     = 4'd0;
        bus.rdata   = 32'd0;
        drive_reqs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr_ok", {bus.i_rd_addr_ok, bus.d_rd_addr_ok}, 2'b00);
        chk("rst_ar", {bus.arvalid, bus.rready, bus.arid, bus.arlen}, 14'd0);
        chk("rst_araddr", bus.araddr, 32'd0);
        chk("rst_data", {bus.i_rd_data, bus.d_rd_data}, 64'd0);
        reset = 1'b0;
        i_pend = 1'b0; d_pend = 1'b0;
        drive_reqs();
        tick();

        // Single inst burst.
        i_pend = 1'b1; i_addr = 32'h1C00_0000; i_len = 8'd3;
        run_txn(0, 1'b0);

        // Simultaneous requests: data first, inst right after the hold-off cycle.
        i_pend = 1'b1; i_addr = 32'h1C00_0040; i_len = 8'd1;
        d_pend = 1'b1; d_addr = 32'h0000_1000; d_len = 8'd1;
        run_txn(0, 1'b0);
        run_txn(0, 1'b0);

        // Starvation: four data grants, then inst; then data wins again from a cleared count.
        i_pend = 1'b1; i_addr = 32'h1C00_0100; i_len = 8'd0;
        for (int n = 0; n < 5; n++) begin
            if (!d_pend) begin
                d_pend = 1'b1; d_addr = 32'h0000_2000 + 32'(n * 16); d_len = 8'd0;
            end
            run_txn(0, 1'b0);
        end
        chk("starve_inst_served", i_pend, 1'b0);
        i_pend = 1'b1; d_pend = 1'b1;
        run_txn(0, 1'b0);
        chk("streak_after_clear", 64'(data_streak), 64'd1);
        run_txn(0, 1'b0);

        // Slow arready.
        d_pend = 1'b1; d_addr = 32'h0000_3000; d_len = 8'd2;
        run_txn(5, 1'b0);

        // Mismatched rid beats dropped.
        d_pend = 1'b1; d_addr = 32'h0000_4000; d_len = 8'd0;
        run_txn(0, 1'b1);

        // Reset during beat 2 of a 4-beat data burst.
        d_pend = 1'b1; d_addr = 32'h0000_5000; d_len = 8'd3;
        drive_reqs();
        #1;
        chk("mr_addr_ok", bus.d_rd_addr_ok, 1'b1);
        d_pend = 1'b0;
        tick();
        drive_reqs();
        bus.arready = 1'b1;
        #1;
        chk("mr_arvalid", bus.arvalid, 1'b1);
        tick();
        bus.arready = 1'b0;
        bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h1111_2222; bus.rlast = 1'b0;
        #1;
        chk("mr_beat1", bus.d_rd_valid, 1'b1);
        tick();
        bus.rdata = 32'hDEAD_BEEF;
        #1;
        chk("mr_beat2", bus.d_rd_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("mr_rst_valid", {bus.d_rd_valid, bus.d_rd_last, bus.i_rd_valid, bus.i_rd_last}, 4'b0000);
        chk("mr_rst_data", bus.d_rd_data, 32'd0);
        chk("mr_rst_ar", {bus.arvalid, bus.rready, bus.arid, bus.arlen}, 14'd0);
        chk("mr_rst_araddr", bus.araddr, 32'd0);
        bus.rvalid = 1'b0;
        tick();
        reset = 1'b0;
        data_streak = 0;
        d_pend = 1'b1; d_addr = 32'h0000_6000; d_len = 8'd1;
        run_txn(1, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            if (!i_pend && $urandom_range(1) == 1) begin
                i_pend = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC; i_len = 8'($urandom_range(0, 3));
            end
            if (!d_pend && ($urandom_range(2) != 0 || !i_pend)) begin
                d_pend = 1'b1; d_addr = $urandom & 32'hFFFF_FFFC; d_len = 8'($urandom_range(0, 3));
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
